// File: rtl/counter_timer_x3_if.sv
// Bus-side signals of the three-channel counter/timer: write strobe, register select,
// write data and combinational read data.
interface counter_timer_x3_if;
    logic        counter_we;
    logic [1:0]  counter_ch;
    logic [31:0] Peripheral_in;
    logic [31:0] counter_out;

    modport master (
        output counter_we,
        output counter_ch,
        output Peripheral_in,
        input  counter_out
    );

    modport slave (
        input  counter_we,
        input  counter_ch,
        input  Peripheral_in,
        output counter_out
    );
endinterface

// File: rtl/counter_timer_x3.sv
// Three down-counting timers with one-shot/periodic reload and sticky W1C expiry flags.
// Optional shared 8-bit prescaler is built only when COUNTER_PRESCALE_EN is defined.
module counter_timer_x3 #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    counter_timer_x3_if.slave   bus,
    output logic                counter0_out,
    output logic                counter1_out,
    output logic                counter2_out
);

    localparam int NCH = 3;

    logic [CNT_W-1:0] cnt_q    [NCH];
    logic [CNT_W-1:0] cnt_d    [NCH];
    logic [CNT_W-1:0] reload_q [NCH];
    logic [CNT_W-1:0] reload_d [NCH];
    logic [NCH-1:0]   en_q,   en_d;
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   flag_q, flag_d;

    logic             tick;
    logic             ctrl_wr;
    logic [NCH-1:0]   ch_wr;
    logic [31:0]      ctrl_img;
    logic [31:0]      rd_data;

    assign ctrl_wr = bus.counter_we && (bus.counter_ch == 2'b11);

`ifdef COUNTER_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] psc_q,      psc_d;

    assign tick = (psc_q == prescale_q);

    // A CTRL write restarts the divider so the first tick lands a full period later.
    always_comb begin
        prescale_d = ctrl_wr ? bus.Peripheral_in[23:16] : prescale_q;
        psc_d      = (ctrl_wr || tick) ? 8'd0 : psc_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= 8'd0;
            psc_q      <= 8'd0;
        end else begin
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // NOTE: every variable gets its default before any branch so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        ch_wr = '0;
        en_d   = en_q;
        mode_d = mode_q;
        for (int i = 0; i < NCH; i++) begin
            ch_wr[i]    = bus.counter_we && (bus.counter_ch == 2'(i));
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];
            flag_d[i]   = flag_q[i];

            if (ctrl_wr) begin
                en_d[i]   = bus.Peripheral_in[2*i];
                mode_d[i] = bus.Peripheral_in[2*i+1];
                if (bus.Peripheral_in[8+i]) flag_d[i] = 1'b0;
            end

            // Expiry set is applied after the W1C clear so set wins; a channel write overrides both.
            if (ch_wr[i]) begin
                cnt_d[i]    = bus.Peripheral_in[CNT_W-1:0];
                reload_d[i] = bus.Peripheral_in[CNT_W-1:0];
                flag_d[i]   = 1'b0;
            end else if (tick && en_q[i] && (cnt_q[i] != '0)) begin
                if (cnt_q[i] == CNT_W'(1)) begin
                    cnt_d[i]  = mode_q[i] ? reload_q[i] : '0;
                    flag_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ctrl_img = '0;
        for (int i = 0; i < NCH; i++) begin
            ctrl_img[2*i]   = en_q[i];
            ctrl_img[2*i+1] = mode_q[i];
            ctrl_img[8+i]   = flag_q[i];
        end
`ifdef COUNTER_PRESCALE_EN
        ctrl_img[23:16] = prescale_q;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (bus.counter_ch)
            2'b00:   rd_data = 32'(cnt_q[0]);
            2'b01:   rd_data = 32'(cnt_q[1]);
            2'b10:   rd_data = 32'(cnt_q[2]);
            default: rd_data = ctrl_img;
        endcase
    end

    assign bus.counter_out = rd_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the count/reload arrays are plain flops, not RAM, so each element is cleared on reset.
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
            en_q   <= '0;
            mode_q <= '0;
            flag_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            flag_q   <= flag_d;
        end
    end

    assign counter0_out = flag_q[0];
    assign counter1_out = flag_q[1];
    assign counter2_out = flag_q[2];

endmodule

// File: doc/counter_timer_x3.md
COUNTER_TIMER_X3 -- requirements
Module: counter_timer_x3

Interface
- REQ-001 The block SHALL have parameter CNT_W, default 32, giving the counter and reload register width.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-004 The block SHALL have port counter_we, input, 1 bit: bus write strobe from the MIO bus decoder.
- REQ-005 The block SHALL have port counter_ch, input, 2 bits: register select; 00/01/10 select channel 0/1/2 count, 11 selects CTRL.
- REQ-006 The block SHALL have port Peripheral_in, input, 32 bits: write data from the bus.
- REQ-007 The block SHALL have port counter_out, output, 32 bits: read data for the selected register.
- REQ-008 The block SHALL have ports counter0_out, counter1_out and counter2_out, each output, 1 bit: sticky expiry flag per channel.

Function
- REQ-009 counter_out SHALL be combinational from counter_ch, with zero-cycle read latency.
  - Channel select: current count, zero-extended.
  - CTRL select: the CTRL image.
- REQ-010 CTRL SHALL have the following layout.
  - Bits [2i]: channel i enable.
  - Bits [2i+1]: channel i periodic mode (1 = auto-reload, 0 = one-shot).
  - Bits [10:8]: expiry flags; reads return the flags, and writing 1 clears the corresponding flag.
  - Bits [23:16]: prescale value.
  - All other bits read 0.
- REQ-011 A write with counter_we=1 to channel i SHALL take effect at the next edge.
  - Reload register and count both load Peripheral_in[CNT_W-1:0].
  - Flag i clears.
- REQ-012 A write to CTRL SHALL update the enable and mode bits at the next edge; counts SHALL be unchanged.
- REQ-013 On each tick (REQ-020), an enabled channel with nonzero count SHALL decrement by 1.
- REQ-014 Expiry SHALL occur on a tick where the count is 1 and the channel is enabled.
  - The flag sets.
  - One-shot: count becomes 0 and stays 0.
  - Periodic: count reloads from the reload register, giving a period of N ticks for a reload value of N.
- REQ-015 With count 0, or with the channel disabled, the count SHALL hold and no expiry SHALL occur.
  - A reload value of 0 never sets the flag.
- REQ-016 When a periodic channel has reload value 1, it SHALL expire on every tick; the count reads 1 throughout and the flag stays set.
- REQ-017 When a channel write coincides with that channel's expiry, the write SHALL win: the loaded value takes effect and the flag stays clear.
- REQ-018 When a CTRL W1C write coincides with expiry of the same channel, the flag SHALL be 1 after the edge (set wins over clear).
- REQ-019 Clearing enable SHALL freeze the count; re-enabling SHALL resume from the frozen value.

Reset
- REQ-020 With COUNTER_PRESCALE_EN undefined, a tick SHALL be every clk cycle.
- REQ-021 While rst=1 at a clock edge, all of the following SHALL clear to 0 at that edge: counts, reload registers, CTRL, flags and the prescaler.
  - counter_out is then 0 for every counter_ch value.
  - counter0_out, counter1_out and counter2_out are 0.
- REQ-022 rst SHALL take priority over a simultaneous counter_we and over a pending expiry; a count in progress SHALL be abandoned without setting its flag.

Configuration
- REQ-023 When macro COUNTER_PRESCALE_EN is defined, an 8-bit prescaler SHALL count clk cycles and generate a tick every (CTRL[23:16]+1) cycles, shared by all channels.
  - A CTRL write restarts the prescaler.
  - Prescale 0 means a tick every cycle.
- REQ-024 When COUNTER_PRESCALE_EN is undefined, CTRL[23:16] SHALL be ignored on write, SHALL read as 0, and no prescaler logic SHALL exist.

Verification
- REQ-025 One-shot: write ch0=5, then CTRL=0x001 → count reads 4,3,2,1,0 on the following ticks; counter0_out rises on the edge where 1→0 and stays 1; count stays 0.
- REQ-026 Periodic: write ch1=3, then CTRL=0x00C → counter1_out sets after 3 ticks; count sequence is 2,1,3,2,1,3; write CTRL=0x20C → flag clears, and it sets again 3 ticks later.
- REQ-027 Collision: ch2 in one-shot, at count 1, write ch2=7 on the expiry cycle → count=7 and counter2_out=0 after the edge.
- REQ-028 Reset mid-count: ch0 running at count 100, assert rst for 1 cycle → counter_out=0 for every counter_ch value, all flags 0, CTRL=0, and no counting after rst deasserts.
- REQ-029 Prescale (COUNTER_PRESCALE_EN defined): CTRL=0x040001, ch0=2 → decrement occurs every 5 clk cycles; counter0_out sets 10 cycles after the CTRL write.
- REQ-030 Zero reload: write ch1=0, periodic and enabled, run 50 cycles → count stays 0 and counter1_out stays 0.
